ogpu_burst_test_mem: RTL and testbench

- Parametrised Avalon-MM slave on-chip memory that holds OpenGPU test and bulk data (quad vertex and command streams) for the HPS and the GPU fetch path.
- Next generation of the single-port test ROM: width and depth are configurable, the read path is pipelined with readdatavalid, and it adds a burst-read engine with waitrequest back-pressure.
- Writes are gated, so contents are effectively read-only unless debug writes are enabled.

---
 rtl/ogpu_mem_pkg.sv | 16 +
 rtl/ogpu_mem_rd_pipe.sv | 50 +++++
 rtl/ogpu_burst_test_mem.sv | 159 +++++++++++++++
 tb/tb_ogpu_burst_test_mem.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ogpu_mem_pkg.sv
// Shared types and constants for the OpenGPU burst test memory.
package ogpu_mem_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int RL_MAX = 2;

    // Largest burst an Avalon master may request with a burstcount of this width.
    function automatic int max_burst(input int burst_w);
        return 1 << (burst_w - 1);
    endfunction

endpackage

// File: rtl/ogpu_mem_rd_pipe.sv
// Read-return pipeline: delays the beat-issue strobe by LATENCY cycles and aligns
// the storage read word with it; readdata is forced to zero while not valid.
module ogpu_mem_rd_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LATENCY-1:0] vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign vld_o = vld_q[LATENCY-1];

    // data_i already comes from the registered storage read, so it lines up with vld_q[0].
    if (LATENCY == 1) begin : g_lat1
        assign data_o = vld_q[0] ? data_i : '0;
    end else begin : g_latn
        logic [LATENCY-2:0][DATA_W-1:0] data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q[0] <= data_i;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end

        assign data_o = vld_q[LATENCY-1] ? data_q[LATENCY-2] : '0;
    end

endmodule

// File: rtl/ogpu_burst_test_mem.sv
// Avalon-MM burst-capable test/bulk-data memory with gated writes.
// Optional OGPU_TEST_MEM_PERF_COUNT_EN adds the rd_beats readdatavalid counter.
module ogpu_burst_test_mem
    import ogpu_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 8192,
    parameter int    ADDR_W       = $clog2(DEPTH),
    parameter int    BURST_W      = 4,
    parameter int    READ_LATENCY = 1,
    parameter int    WRITABLE     = 0,
    parameter string INIT_FILE    = "ogpu_quad_data_test.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                debugaccess,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                wr_reject
`ifdef OGPU_TEST_MEM_PERF_COUNT_EN
    ,
    output logic [31:0]         rd_beats
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam int RL   = (READ_LATENCY < 1) ? 1 :
                          ((READ_LATENCY > RL_MAX) ? RL_MAX : READ_LATENCY);
    localparam int MAXB = max_burst(BURST_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BURST_W-1:0]  beats_left_q;
    logic                wr_reject_q;

    logic                accept, rd_accept, wr_accept, wr_ok, wr_in_range;
    logic                issue_vld, issue_oob;
    logic [ADDR_W-1:0]   issue_addr;
    logic [BURST_W-1:0]  beats_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   ram_rd_q;
    logic                oob_q;
    logic [DATA_W-1:0]   rd_word;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    assign waitrequest = reset | reset_req | (state_q == BURST);
    assign accept      = chipselect & ~waitrequest & (read | write);
    assign rd_accept   = accept & read;
    assign wr_accept   = accept & write & ~read;
    assign wr_in_range = (int'(address) < DEPTH);
    assign wr_ok       = wr_accept & ((WRITABLE != 0) | debugaccess) & wr_in_range;

    always_comb begin
        beats_d = burstcount;
        if (burstcount == '0) begin
            beats_d = BURST_W'(1);
        end else if (int'(burstcount) > MAXB) begin
            beats_d = BURST_W'(MAXB);
        end
    end

    assign issue_vld  = rd_accept | (state_q == BURST);
    assign issue_addr = (state_q == BURST) ? addr_q : address;
    assign issue_oob  = (int'(issue_addr) >= DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            wr_reject_q  <= 1'b0;
        end else begin
            // Any accepted write that does not land (gated, out of range, or paired with a read).
            wr_reject_q <= accept & write & ~wr_ok;
            case (state_q)
                IDLE: begin
                    if (rd_accept && (beats_d > BURST_W'(1))) begin
                        state_q      <= BURST;
                        addr_q       <= next_addr(address);
                        beats_left_q <= beats_d - BURST_W'(1);
                    end
                end
                BURST: begin
                    addr_q       <= next_addr(addr_q);
                    beats_left_q <= beats_left_q - BURST_W'(1);
                    if (beats_left_q == BURST_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is never reset; registered read keeps it in block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    mem_q[address][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
        if (issue_vld) begin
            ram_rd_q <= mem_q[issue_addr];
            oob_q    <= issue_oob;
        end
    end

    assign rd_word = oob_q ? '0 : ram_rd_q;

    ogpu_mem_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (RL)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (reset),
        .vld_i  (issue_vld),
        .data_i (rd_word),
        .vld_o  (readdatavalid),
        .data_o (readdata)
    );

    assign wr_reject = wr_reject_q;

`ifdef OGPU_TEST_MEM_PERF_COUNT_EN
    logic [31:0] rd_beats_q;
    logic        perf_clr;

    assign perf_clr = wr_accept & debugaccess & (address == LAST_ADDR) & (&byteenable);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_beats_q <= '0;
        end else if (perf_clr) begin
            rd_beats_q <= '0;
        end else if (readdatavalid && (rd_beats_q != 32'hFFFF_FFFF)) begin
            rd_beats_q <= rd_beats_q + 32'd1;
        end
    end

    assign rd_beats = rd_beats_q;
`endif

endmodule

// File: tb/tb_ogpu_burst_test_mem.sv
// Scoreboard bench for ogpu_burst_test_mem: one instance per read latency (1 and 2),
// each with a word-array reference model, a driver and an independent monitor.
module tb_ogpu_burst_test_mem;

    localparam int DEPTH = 12;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [31:0] data;
        int          due;
    } beat_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int RL = gi + 1;

        logic          reset = 1'b1;
        logic          reset_req = 1'b0;
        logic          chipselect = 1'b0;
        logic          read = 1'b0;
        logic          write = 1'b0;
        logic          debugaccess = 1'b0;
        logic [AW-1:0] address = '0;
        logic [3:0]    burstcount = '0;
        logic [3:0]    byteenable = '0;
        logic [31:0]   writedata = '0;
        logic          waitrequest;
        logic          readdatavalid;
        logic          wr_reject;
        logic [31:0]   readdata;
`ifdef OGPU_TEST_MEM_PERF_COUNT_EN
        logic [31:0]   rd_beats;
`endif

        logic [31:0] model_mem [DEPTH];
        beat_t       exp_q [$];
        int          rej_q [$];
        int          busy_until = 0;
        int          last_a = 0;
        bit          done_i = 1'b0;

        ogpu_burst_test_mem #(
            .DATA_W       (32),
            .DEPTH        (DEPTH),
            .BURST_W      (4),
            .READ_LATENCY (RL),
            .WRITABLE     (0),
            .INIT_FILE    ("")
        ) dut (
            .clk           (clk),
            .reset         (reset),
            .reset_req     (reset_req),
            .address       (address),
            .chipselect    (chipselect),
            .read          (read),
            .write         (write),
            .burstcount    (burstcount),
            .byteenable    (byteenable),
            .writedata     (writedata),
            .debugaccess   (debugaccess),
            .waitrequest   (waitrequest),
            .readdata      (readdata),
            .readdatavalid (readdatavalid),
            .wr_reject     (wr_reject)
`ifdef OGPU_TEST_MEM_PERF_COUNT_EN
            ,
            .rd_beats      (rd_beats)
`endif
        );

        function automatic int next_word(input int a);
            return (a == DEPTH - 1) ? 0 : a + 1;
        endfunction

        task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL rl%0d %s: got %h, required %h (cycle %0d)", RL, what, act, req, cyc);
            end
        endtask

        // Issue one command and hold it until the model says the slave takes it.
        task automatic cmd(input bit rd, input bit wr, input int addr, input int bc,
                           input logic [31:0] wd, input logic [3:0] be, input bit dbg);
            bit    ok;
            bit    exp_wait;
            int    a;
            int    beats;
            int    w;
            beat_t e;
            ok = 1'b0;
            @(negedge clk);
            chipselect  = 1'b1;
            read        = rd;
            write       = wr;
            address     = AW'(addr);
            burstcount  = 4'(bc);
            writedata   = wd;
            byteenable  = be;
            debugaccess = dbg;
            for (int t = 0; t < 40 && !ok; t++) begin
                #1;
                exp_wait = reset_req || (cyc < busy_until);
                check("waitrequest", 32'(waitrequest), 32'(exp_wait));
                if (!exp_wait) ok = 1'b1;
                else @(negedge clk);
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL rl%0d command accept timeout: got waitrequest %0b, required a grant within 40 cycles",
                         RL, waitrequest);
            end else begin
                a      = cyc + 1;
                last_a = a;
                if (rd) begin
                    beats = (bc == 0) ? 1 : bc;
                    w     = addr;
                    for (int k = 0; k < beats; k++) begin
                        e.data = (w < DEPTH) ? model_mem[w] : 32'h0;
                        e.due  = a + k + RL - 1;
                        exp_q.push_back(e);
                        w = next_word(w);
                    end
                    busy_until = a + beats - 1;
                end
                if (wr) begin
                    if (rd || !dbg || addr >= DEPTH) begin
                        rej_q.push_back(a);
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[b]) model_mem[addr][8*b +: 8] = wd[8*b +: 8];
                        end
                    end
                end
                @(posedge clk);
                #1;
            end
            chipselect  = 1'b0;
            read        = 1'b0;
            write       = 1'b0;
            debugaccess = 1'b0;
        endtask

        // Monitor: independent of the driver, compares whatever the DUT presents.
        initial begin
            bit    exp_rej;
            beat_t e;
            forever begin
                @(negedge clk);
                exp_rej = 1'b0;
                if (rej_q.size() > 0 && rej_q[0] == cyc) begin
                    exp_rej = 1'b1;
                    void'(rej_q.pop_front());
                end
                check("wr_reject", 32'(wr_reject), 32'(exp_rej));
                if (readdatavalid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rl%0d spurious readdatavalid: got data %h, required no beat (cycle %0d)",
                                 RL, readdata, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat cycle", 32'(cyc), 32'(e.due));
                        check("beat data", readdata, e.data);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL rl%0d missing beat: got readdatavalid 0, required data %h at cycle %0d",
                             RL, e.data, e.due);
                end
            end
        end

        initial begin
            logic [31:0] v;
            int          r;
            repeat (2) @(negedge clk);
            #1;
            check("reset waitrequest", 32'(waitrequest), 32'd1);
            check("reset readdatavalid", 32'(readdatavalid), 32'd0);
            check("reset readdata", readdata, 32'd0);
            check("reset wr_reject", 32'(wr_reject), 32'd0);
            @(negedge clk);
            reset = 1'b0;

            // Image load through debug writes.
            for (int i = 0; i < DEPTH; i++) begin
                v = (i == 0) ? 32'h1111_1111 : (i == 1) ? 32'h2222_2222 : (i == 5) ? 32'h0 : $urandom;
                cmd(1'b0, 1'b1, i, 0, v, 4'hF, 1'b1);
            end

            cmd(1'b1, 1'b0, 0, 1, 32'h0, 4'h0, 1'b0);
            cmd(1'b1, 1'b0, 1, 1, 32'h0, 4'h0, 1'b0);
            cmd(1'b1, 1'b0, DEPTH - 2, 4, 32'h0, 4'h0, 1'b0);
            cmd(1'b0, 1'b1, 5, 0, 32'hAABB_CCDD, 4'b0101, 1'b1);
            cmd(1'b1, 1'b0, 5, 1, 32'h0, 4'h0, 1'b0);
            cmd(1'b0, 1'b1, 3, 0, 32'hDEAD_BEEF, 4'hF, 1'b0);
            cmd(1'b1, 1'b0, 3, 1, 32'h0, 4'h0, 1'b0);
            cmd(1'b1, 1'b1, 4, 1, 32'h1234_5678, 4'hF, 1'b1);
            cmd(1'b1, 1'b0, 4, 0, 32'h0, 4'h0, 1'b0);
            cmd(1'b1, 1'b0, DEPTH + 1, 1, 32'h0, 4'h0, 1'b0);
            cmd(1'b0, 1'b1, DEPTH + 2, 0, 32'h5555_AAAA, 4'hF, 1'b1);

            // Asynchronous reset while the second beat of an 8-beat burst is on the bus.
            cmd(1'b1, 1'b0, 2, 8, 32'h0, 4'h0, 1'b0);
            while (cyc < last_a + RL) @(negedge clk);
            #2;
            reset = 1'b1;
            exp_q.delete();
            rej_q.delete();
            busy_until = 0;
            #1;
            check("reset mid-burst readdatavalid", 32'(readdatavalid), 32'd0);
            check("reset mid-burst waitrequest", 32'(waitrequest), 32'd1);
            check("reset mid-burst readdata", readdata, 32'd0);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            cmd(1'b1, 1'b0, 1, 1, 32'h0, 4'h0, 1'b0);

            // Quiesce request mid-burst: burst finishes, next command waits for release.
            cmd(1'b1, 1'b0, 6, 4, 32'h0, 4'h0, 1'b0);
            @(negedge clk);
            reset_req = 1'b1;
            fork
                begin
                    repeat (6) @(negedge clk);
                    reset_req = 1'b0;
                end
                cmd(1'b1, 1'b0, 0, 2, 32'h0, 4'h0, 1'b0);
            join

            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r < 4) begin
                    cmd(1'b1, 1'b0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 8), 32'h0, 4'h0, 1'b0);
                end else if (r < 5) begin
                    cmd(1'b1, 1'b0, $urandom_range(DEPTH, 15), 1, 32'h0, 4'h0, 1'b0);
                end else if (r < 8) begin
                    cmd(1'b0, 1'b1, $urandom_range(0, 15), 0, $urandom, 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)));
                end else begin
                    cmd(1'b1, 1'b1, $urandom_range(0, DEPTH - 1), 1, $urandom, 4'hF, 1'b1);
                end
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end

            repeat (12) @(negedge clk);
            #1;
            check("scoreboard drained", 32'(exp_q.size() + rej_q.size()), 32'd0);
            done_i = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_dut[0].done_i && g_dut[1].done_i) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            failures++;
            $display("FAIL run timeout: got drivers still busy after %0d cycles, required completion", n);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
